// File: rtl/holy_trace_pkg.sv
// Shared types and constants for the holy trace buffer.
package holy_trace_pkg;

  // Width of the core's debug flag bundle and the positions of the stall bits
  localparam int TRACE_FLAGS_W = 10;
  localparam int FLAG_I_STALL  = 6;
  localparam int FLAG_D_STALL  = 7;

  // Native core widths used by the default entry layout
  localparam int TRACE_ADDR_W  = 32;
  localparam int TRACE_INSTR_W = 32;

  typedef struct packed {
    logic [TRACE_ADDR_W-1:0]  pc;
    logic [TRACE_INSTR_W-1:0] instr;
    logic [TRACE_FLAGS_W-1:0] flags;
  } trace_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_t;

endpackage

// File: rtl/holy_trace_ram.sv
// Trace storage: one write port, one registered read port (distributed-RAM friendly).
module holy_trace_ram
  import holy_trace_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = TRACE_ADDR_W + TRACE_INSTR_W + TRACE_FLAGS_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             re,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Registered read; holds its value while re is low so readout stays stable
  always_ff @(posedge clk) begin
    if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/holy_trace_buffer.sv
// Circular debug trace buffer: captures core snapshots, freezes POST_TRIG
// entries after a PC-match trigger, then plays them out oldest first.
module holy_trace_buffer
  import holy_trace_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int INSTR_W     = 32,
  parameter int DEPTH       = 64,
  parameter int POST_TRIG   = 16,
  parameter int CHANGE_ONLY = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arm,
  input  logic                     trig_en,
  input  logic [ADDR_W-1:0]        trig_pc,
  input  logic [ADDR_W-1:0]        dbg_pc,
  input  logic [INSTR_W-1:0]       dbg_instr,
  input  logic [TRACE_FLAGS_W-1:0] dbg_flags,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [ADDR_W-1:0]        rd_pc,
  output logic [INSTR_W-1:0]       rd_instr,
  output logic [TRACE_FLAGS_W-1:0] rd_flags,
  output logic                     rd_last,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int FILL_W  = PTR_W + 1;
  localparam int ENTRY_W = ADDR_W + INSTR_W + TRACE_FLAGS_W;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
  localparam logic [PTR_W-1:0]  POST_LAST = PTR_W'(POST_TRIG);

  trace_state_t       st_q, st_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q, post_cnt_q;
  logic [FILL_W-1:0]  fill_q;
  logic [ADDR_W-1:0]  last_pc_q;
  logic               last_pc_vld_q;
  logic               rd_valid_q;

  logic               cap, trig_hit, post_done, to_done, pop, load;
  logic [PTR_W-1:0]   wr_ptr_nx;
  logic [FILL_W-1:0]  fill_nx;
  logic [ENTRY_W-1:0] rd_data;

  // Capture qualifier, trigger detection and readout handshakes
  always_comb begin
    cap = (st_q == ST_ARMED || st_q == ST_POST) && !arm &&
          !dbg_flags[FLAG_I_STALL] && !dbg_flags[FLAG_D_STALL] &&
          ((CHANGE_ONLY == 0) || !last_pc_vld_q || (dbg_pc != last_pc_q));
    trig_hit  = cap && (st_q == ST_ARMED) && trig_en && (dbg_pc == trig_pc);
    post_done = cap && (st_q == ST_POST) && ((post_cnt_q + 1'b1) == POST_LAST);
    to_done   = (trig_hit && (POST_TRIG == 0)) || post_done;
    pop       = (st_q == ST_DONE) && rd_valid_q && rd_ready;
    load      = (st_q == ST_DONE) && !rd_valid_q && !arm;
    wr_ptr_nx = wr_ptr_q + 1'b1;
    fill_nx   = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
  end

  // Next-state logic; arm overrides every state
  always_comb begin
    st_d = st_q;
    if (arm) begin
      st_d = ST_ARMED;
    end else begin
      case (st_q)
        ST_IDLE:  st_d = ST_IDLE;
        ST_ARMED: if (trig_hit) st_d = (POST_TRIG == 0) ? ST_DONE : ST_POST;
        ST_POST:  if (post_done) st_d = ST_DONE;
        ST_DONE:  if (pop && rd_last) st_d = ST_IDLE;
        default:  st_d = ST_IDLE;
      endcase
    end
  end

  // Control registers: pointers, occupancy, post-trigger count, readout valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q          <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fill_q        <= '0;
      post_cnt_q    <= '0;
      rd_valid_q    <= 1'b0;
      last_pc_vld_q <= 1'b0;
    end else begin
      st_q <= st_d;
      if (arm) begin
        wr_ptr_q      <= '0;
        rd_ptr_q      <= '0;
        fill_q        <= '0;
        post_cnt_q    <= '0;
        rd_valid_q    <= 1'b0;
        last_pc_vld_q <= 1'b0;
      end else begin
        if (cap) begin
          wr_ptr_q      <= wr_ptr_nx;
          fill_q        <= fill_nx;
          last_pc_vld_q <= 1'b1;
        end
        if (trig_hit) post_cnt_q <= '0;
        else if (cap && st_q == ST_POST) post_cnt_q <= post_cnt_q + 1'b1;
        // Oldest surviving entry sits at the post-write pointer once full
        if (to_done) rd_ptr_q <= (fill_nx == FILL_FULL) ? wr_ptr_nx : '0;
        if (load) rd_valid_q <= 1'b1;
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
          fill_q   <= fill_q - 1'b1;
          if (rd_last) rd_valid_q <= 1'b0;
        end
      end
    end
  end

  // Last captured pc for the change-only filter (data, not reset)
  always_ff @(posedge clk) begin
    if (cap) last_pc_q <= dbg_pc;
  end

  // A pop prefetches the following entry so rd_* track rd_ptr
  holy_trace_ram #(.DEPTH(DEPTH), .WIDTH(ENTRY_W), .AW(PTR_W)) u_ram (
    .clk     (clk),
    .we      (cap),
    .wr_addr (wr_ptr_q),
    .wr_data ({dbg_pc, dbg_instr, dbg_flags}),
    .re      (load || pop),
    .rd_addr (pop ? rd_ptr_q + 1'b1 : rd_ptr_q),
    .rd_data (rd_data)
  );

  assign {rd_pc, rd_instr, rd_flags} = rd_data;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_valid_q && (fill_q == FILL_W'(1));
  assign state    = st_q;
  assign fill     = fill_q;

endmodule

// File: tb/tb_holy_trace_buffer.sv
// Directed bench for holy_trace_buffer: two instances differing only in CHANGE_ONLY.
module tb_holy_trace_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm, trig_en, rd_ready;
  logic [31:0] trig_pc, dbg_pc, dbg_instr;
  logic [9:0]  dbg_flags;

  logic        rd_valid, rd_last, rd_valid_b, rd_last_b;
  logic [31:0] rd_pc, rd_instr, rd_pc_b, rd_instr_b;
  logic [9:0]  rd_flags, rd_flags_b;
  logic [1:0]  state, state_b;
  logic [6:0]  fill, fill_b;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  holy_trace_buffer #(.ADDR_W(32), .INSTR_W(32), .DEPTH(64), .POST_TRIG(4), .CHANGE_ONLY(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .dbg_pc(dbg_pc), .dbg_instr(dbg_instr), .dbg_flags(dbg_flags),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_instr(rd_instr),
    .rd_flags(rd_flags), .rd_last(rd_last), .state(state), .fill(fill)
  );

  holy_trace_buffer #(.ADDR_W(32), .INSTR_W(32), .DEPTH(64), .POST_TRIG(4), .CHANGE_ONLY(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .dbg_pc(dbg_pc), .dbg_instr(dbg_instr), .dbg_flags(dbg_flags),
    .rd_valid(rd_valid_b), .rd_ready(rd_ready), .rd_pc(rd_pc_b), .rd_instr(rd_instr_b),
    .rd_flags(rd_flags_b), .rd_last(rd_last_b), .state(state_b), .fill(fill_b)
  );

  typedef struct {
    logic [31:0] pc;
    logic [9:0]  flags;
    logic [6:0]  fill_a;
    logic [6:0]  fill_b;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hC0DE_0000 ^ pc;
  endfunction

  function automatic logic [9:0] flags_of(input logic [31:0] pc);
    return {4'b0000, pc[7:2]};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [9:0] fl);
    dbg_pc    = pc;
    dbg_instr = instr_of(pc);
    dbg_flags = fl;
    step();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  // Pop n_pop entries expected at first, first+4, ...; total is the trace length
  task automatic drain(input logic [31:0] first, input int n_pop, input int total, input bit bp);
    int waited;
    logic [31:0] pc;
    waited = 0;
    while (!rd_valid && waited < 8) begin
      step();
      waited++;
    end
    if (!rd_valid) begin
      n_run++;
      n_fail++;
      $display("FAIL drain_timeout: rd_valid=%0b expected 1", rd_valid);
      return;
    end
    for (int i = 0; i < n_pop; i++) begin
      pc = first + 32'(4 * i);
      if (bp) begin
        rd_ready = 1'b0;
        step();
        chk("hold_pc", 128'(rd_pc), 128'(pc));
        chk("hold_fill", 128'(fill), 128'(total - i));
      end
      chk("rd_valid", 128'(rd_valid), 128'(1'b1));
      chk("rd_pc", 128'(rd_pc), 128'(pc));
      chk("rd_instr", 128'(rd_instr), 128'(instr_of(pc)));
      chk("rd_flags", 128'(rd_flags), 128'(flags_of(pc)));
      chk("rd_last", 128'(rd_last), 128'(i == total - 1));
      chk("b_entry", 128'({rd_valid_b, rd_last_b, rd_pc_b, rd_instr_b, rd_flags_b}),
          128'({1'b1, (i == total - 1), pc, instr_of(pc), flags_of(pc)}));
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
    end
  endtask

  initial begin
    vecs[0] = '{32'h40, 10'h000, 7'd1, 7'd1};
    vecs[1] = '{32'h40, 10'h000, 7'd1, 7'd2};
    vecs[2] = '{32'h40, 10'h000, 7'd1, 7'd3};
    vecs[3] = '{32'h40, 10'h000, 7'd1, 7'd4};
    vecs[4] = '{32'h40, 10'h000, 7'd1, 7'd5};
    vecs[5] = '{32'h44, 10'h040, 7'd1, 7'd5};
    vecs[6] = '{32'h48, 10'h040, 7'd1, 7'd5};
    vecs[7] = '{32'h4C, 10'h040, 7'd1, 7'd5};
    vecs[8] = '{32'h44, 10'h000, 7'd2, 7'd6};
    vecs[9] = '{32'h48, 10'h080, 7'd2, 7'd6};

    rst_n = 1'b0; arm = 1'b0; trig_en = 1'b0; rd_ready = 1'b0;
    trig_pc = '0; dbg_pc = '0; dbg_instr = '0; dbg_flags = '0;
    #12;
    chk("rst_state", 128'(state), 128'(2'd0));
    chk("rst_fill", 128'(fill), 128'(7'd0));
    chk("rst_valid", 128'({rd_valid, rd_last}), 128'(2'b00));
    rst_n = 1'b1;
    step();

    // No-wrap trace: trigger at 0x10, four post entries
    trig_en = 1'b1; trig_pc = 32'h10;
    do_arm();
    chk("arm_state", 128'(state), 128'(2'd1));
    for (int k = 0; k < 10; k++) begin
      drive(32'(4 * k), flags_of(32'(4 * k)));
      if (k == 4) chk("nw_post", 128'(state), 128'(2'd2));
      if (k == 7) chk("nw_not_done", 128'(state), 128'(2'd2));
      if (k == 8) begin
        chk("nw_done", 128'(state), 128'(2'd3));
        chk("nw_latency", 128'(rd_valid), 128'(1'b0));
      end
    end
    chk("nw_fill", 128'(fill), 128'(7'd9));
    chk("nw_valid", 128'(rd_valid), 128'(1'b1));
    drain(32'h0, 9, 9, 1'b0);
    chk("nw_idle", 128'({state, rd_valid, fill}), 128'({2'd0, 1'b0, 7'd0}));

    // Wrap: 100 captures without trigger, then trigger at 0x1190
    trig_en = 1'b0; trig_pc = 32'h1190;
    do_arm();
    for (int k = 0; k < 100; k++) drive(32'h1000 + 32'(4 * k), flags_of(32'h1000 + 32'(4 * k)));
    chk("wr_full", 128'(fill), 128'(7'd64));
    chk("wr_armed", 128'(state), 128'(2'd1));
    trig_en = 1'b1;
    for (int k = 100; k < 105; k++) begin
      drive(32'h1000 + 32'(4 * k), flags_of(32'h1000 + 32'(4 * k)));
      if (k == 100) chk("wr_post", 128'(state), 128'(2'd2));
    end
    chk("wr_done", 128'(state), 128'(2'd3));
    chk("wr_fill", 128'(fill), 128'(7'd64));
    drain(32'h10A4, 64, 64, 1'b1);
    chk("wr_idle", 128'({state, fill}), 128'({2'd0, 7'd0}));

    // Stall / change-only filter
    trig_en = 1'b0;
    do_arm();
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].pc, vecs[i].flags);
      chk($sformatf("flt_a[%0d]", i), 128'(fill), 128'(vecs[i].fill_a));
      chk($sformatf("flt_b[%0d]", i), 128'(fill_b), 128'(vecs[i].fill_b));
    end

    // Arm in the same cycle as a trigger match wins
    trig_en = 1'b1; trig_pc = 32'h200;
    do_arm();
    drive(32'h1FC, flags_of(32'h1FC));
    chk("ap_fill1", 128'(fill), 128'(7'd1));
    arm = 1'b1;
    drive(32'h200, flags_of(32'h200));
    arm = 1'b0;
    chk("ap_same", 128'({state, fill, rd_valid}), 128'({2'd1, 7'd0, 1'b0}));
    chk("ap_same_b", 128'({state_b, fill_b}), 128'({2'd1, 7'd0}));
    for (int k = 0; k < 5; k++) drive(32'h200 + 32'(4 * k), flags_of(32'h200 + 32'(4 * k)));
    chk("ap_done", 128'({state, fill}), 128'({2'd3, 7'd5}));
    drain(32'h200, 2, 5, 1'b0);
    chk("ap_mid", 128'({state, fill}), 128'({2'd3, 7'd3}));
    do_arm();
    chk("ap_rearm", 128'({state, fill, rd_valid}), 128'({2'd1, 7'd0, 1'b0}));

    // Asynchronous reset in the middle of POST
    trig_pc = 32'h300;
    drive(32'h300, flags_of(32'h300));
    drive(32'h304, flags_of(32'h304));
    chk("rs_post", 128'({state, fill}), 128'({2'd2, 7'd2}));
    #2 rst_n = 1'b0;
    #1;
    chk("rs_async", 128'({state, fill, rd_valid}), 128'({2'd0, 7'd0, 1'b0}));
    #2 rst_n = 1'b1;
    step();
    chk("rs_hold", 128'(state), 128'(2'd0));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
